thread_context_regs: RTL and testbench

THREAD_CONTEXT_REGS -- requirements
Module: thread_context_regs

---
 rtl/thread_context_regs_if.sv | 53 +++++
 rtl/thread_context_regs.sv | 135 +++++++++++++
 tb/tb_thread_context_regs.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/thread_context_regs_if.sv
// ----------------------------------------------------------------------------
// thread_context_regs_if
//   Bundles the read port, write port and scheduler signals of
//   thread_context_regs. The design takes the slave modport. The controlling
//   side (pipeline front end or testbench) takes the master modport.
//
//   Read port    : rthreadid -> qpc, qflags, qrun
//   Write port   : wthreadid, dpc/wepc, incpc, dflags/weflags, setrun, clrrun
//   Scheduler    : sched_en -> next_thread, next_valid, cur_thread
// ----------------------------------------------------------------------------
interface thread_context_regs_if #(
    parameter int TIDW  = 5,
    parameter int PCW   = 12,
    parameter int FLAGW = 4
);
    // read port
    logic [TIDW-1:0]  rthreadid;
    logic [PCW-1:0]   qpc;
    logic [FLAGW-1:0] qflags;
    logic             qrun;

    // write port
    logic [TIDW-1:0]  wthreadid;
    logic [PCW-1:0]   dpc;
    logic             wepc;
    logic             incpc;
    logic [FLAGW-1:0] dflags;
    logic             weflags;
    logic             setrun;
    logic             clrrun;

    // scheduler
    logic             sched_en;
    logic [TIDW-1:0]  next_thread;
    logic             next_valid;
    logic [TIDW-1:0]  cur_thread;

    modport master (
        output rthreadid,
        output wthreadid, dpc, wepc, incpc, dflags, weflags, setrun, clrrun,
        output sched_en,
        input  qpc, qflags, qrun,
        input  next_thread, next_valid, cur_thread
    );

    modport slave (
        input  rthreadid,
        input  wthreadid, dpc, wepc, incpc, dflags, weflags, setrun, clrrun,
        input  sched_en,
        output qpc, qflags, qrun,
        output next_thread, next_valid, cur_thread
    );
endinterface

// File: rtl/thread_context_regs.sv
// ----------------------------------------------------------------------------
// thread_context_regs
//   Per-thread context storage for a barrel-style multithreaded core. Each of
//   THREADS hardware threads owns a PC, a flags field and a runnable bit. One
//   write port updates the context of bus.wthreadid and one combinational read
//   port returns the context of bus.rthreadid. A round-robin scheduler picks
//   the next runnable thread after cur_thread and advances on sched_en.
//
// Ports
//   clk    : sole clock, all state updates on the rising edge
//   reset  : synchronous active-high reset
//   bus    : thread_context_regs_if.slave (read, write and scheduler signals)
//
// Parameters
//   THREADS  : number of threads, power of two in 2..64
//   TIDW     : thread-id width, must equal log2(THREADS)
//   PCW      : program-counter width
//   FLAGW    : per-thread flags width
//   RESET_PC : PC loaded into every thread on reset
//
// The interface instance must be parameterised with the same TIDW/PCW/FLAGW.
// ----------------------------------------------------------------------------
module thread_context_regs #(
    parameter int             THREADS  = 32,
    parameter int             TIDW     = 5,
    parameter int             PCW      = 12,
    parameter int             FLAGW    = 4,
    parameter logic [PCW-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    thread_context_regs_if.slave  bus
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [PCW-1:0]     pc_q    [THREADS];
    logic [FLAGW-1:0]   flags_q [THREADS];
    logic [THREADS-1:0] run_q;
    logic [TIDW-1:0]    cur_q;

    // Scheduler search results
    logic [TIDW-1:0]    pick;
    logic [TIDW-1:0]    cand;
    logic               any_run;

    // Reset values kept as localparams so the reset branch reads plainly
    localparam logic [THREADS-1:0] RUN_RESET = {{(THREADS-1){1'b0}}, 1'b1};
    localparam logic [TIDW-1:0]    CUR_RESET = TIDW'(THREADS - 1);

    // ------------------------------------------------------------------------
    // Round-robin pick
    //   The search order is cur+1, cur+2, ... cur+THREADS (= cur itself).
    //   The loop runs from the farthest offset down to the nearest. Each
    //   runnable candidate overwrites the previous one, so the nearest
    //   runnable thread after cur_q wins without an early exit.
    //   The offset i = THREADS truncates to 0, which makes the final candidate
    //   cur_q itself. When cur_q is the only runnable thread, it is picked
    //   again.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        pick = cur_q;
        cand = '0;
        for (int i = THREADS; i >= 1; i--) begin
            cand = cur_q + TIDW'(i);
            if (run_q[cand]) begin
                pick = cand;
            end
        end
    end

    assign any_run = |run_q;

    // ------------------------------------------------------------------------
    // Context registers and scheduler pointer
    //   Only the entry addressed by wthreadid is touched. All other threads
    //   hold their value.
    //   The PC load takes priority over the increment. The run clear takes
    //   priority over the run set.
    //   cur_q is updated from the pick computed on this cycle's run bits, so a
    //   setrun/clrrun issued in the same cycle affects the pick only after the
    //   edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            // NOTE: the context arrays are reset explicitly. Software relies
            // on every thread starting at RESET_PC with clear flags, so these
            // cannot be treated as uninitialised RAM.
            for (int t = 0; t < THREADS; t++) begin
                pc_q[t]    <= RESET_PC;
                flags_q[t] <= '0;
            end
            run_q <= RUN_RESET;
            cur_q <= CUR_RESET;
        end else begin
            if (bus.wepc) begin
                pc_q[bus.wthreadid] <= bus.dpc;
            end else if (bus.incpc) begin
                pc_q[bus.wthreadid] <= pc_q[bus.wthreadid] + PCW'(1);
            end

            if (bus.weflags) begin
                flags_q[bus.wthreadid] <= bus.dflags;
            end

            if (bus.clrrun) begin
                run_q[bus.wthreadid] <= 1'b0;
            end else if (bus.setrun) begin
                run_q[bus.wthreadid] <= 1'b1;
            end

            if (bus.sched_en && any_run) begin
                cur_q <= pick;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    //   Reads come straight from stored state. A write is seen only after the
    //   edge that commits it; there is no write-to-read bypass.
    // ------------------------------------------------------------------------
    assign bus.qpc         = pc_q[bus.rthreadid];
    assign bus.qflags      = flags_q[bus.rthreadid];
    assign bus.qrun        = run_q[bus.rthreadid];
    assign bus.next_thread = pick;
    assign bus.next_valid  = any_run;
    assign bus.cur_thread  = cur_q;

endmodule

// File: tb/tb_thread_context_regs.sv
// ----------------------------------------------------------------------------
// tb_thread_context_regs
//   Self-checking bench for thread_context_regs. A 32-thread/12-bit instance
//   and a 4-thread/16-bit instance share the clock and reset. Single-cycle
//   register operations come from a vector table. The expected context is
//   pushed to a scoreboard queue when a vector is driven, then popped and
//   compared after the edge. Scheduler and reset corner cases are
//   hand-written sequences.
// ----------------------------------------------------------------------------
module tb_thread_context_regs;

    localparam int T   = 32;
    localparam int TW  = 5;
    localparam int PW  = 12;
    localparam int FW  = 4;
    localparam int ST  = 4;
    localparam int STW = 2;
    localparam int SPW = 16;
    localparam logic [SPW-1:0] S_RESET_PC = 16'h0100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    thread_context_regs_if #(.TIDW(TW),  .PCW(PW),  .FLAGW(FW)) b ();
    thread_context_regs_if #(.TIDW(STW), .PCW(SPW), .FLAGW(FW)) s ();

    thread_context_regs #(
        .THREADS(T), .TIDW(TW), .PCW(PW), .FLAGW(FW), .RESET_PC(12'h000)
    ) dut (
        .clk(clk), .reset(reset), .bus(b.slave)
    );

    thread_context_regs #(
        .THREADS(ST), .TIDW(STW), .PCW(SPW), .FLAGW(FW), .RESET_PC(S_RESET_PC)
    ) dut_small (
        .clk(clk), .reset(reset), .bus(s.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         tid;
        logic [PW-1:0] dpc;
        logic       wepc;
        logic       incpc;
        logic [FW-1:0] dflags;
        logic       weflags;
        logic       setrun;
        logic       clrrun;
        logic [PW-1:0] epc;
        logic [FW-1:0] eflags;
        logic       erun;
    } vec_t;

    typedef struct {
        string       name;
        int          tid;
        logic [31:0] pc;
        logic [31:0] flags;
        logic [31:0] run;
    } exp_t;

    vec_t vecs [14];
    exp_t sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_main();
        b.wepc = 1'b0; b.incpc = 1'b0; b.weflags = 1'b0;
        b.setrun = 1'b0; b.clrrun = 1'b0; b.sched_en = 1'b0;
        b.dpc = '0; b.dflags = '0;
    endtask

    task automatic clr_small();
        s.wepc = 1'b0; s.incpc = 1'b0; s.weflags = 1'b0;
        s.setrun = 1'b0; s.clrrun = 1'b0; s.sched_en = 1'b0;
        s.dpc = '0; s.dflags = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Pop one scoreboard entry and compare the addressed thread's context.
    task automatic sb_check();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            b.rthreadid = TW'(e.tid);
            #1;
            check({e.name, "_pc"},    32'(b.qpc),    e.pc);
            check({e.name, "_flags"}, 32'(b.qflags), e.flags);
            check({e.name, "_run"},   32'(b.qrun),   e.run);
        end
    endtask

    initial begin
        // tid   dpc     wepc  incpc dflags weflags setrun clrrun | pc      flags run
        vecs[0]  = '{3,  12'hFFF, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 12'hFFF, 4'h0, 1'b0};
        vecs[1]  = '{3,  12'h000, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 12'h000, 4'h0, 1'b0};
        vecs[2]  = '{3,  12'h123, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 12'h123, 4'h0, 1'b0};
        vecs[3]  = '{3,  12'h000, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 12'h124, 4'h0, 1'b0};
        vecs[4]  = '{3,  12'h000, 1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 1'b0, 12'h125, 4'hA, 1'b0};
        vecs[5]  = '{3,  12'h000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 12'h125, 4'hA, 1'b1};
        vecs[6]  = '{3,  12'h000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 12'h125, 4'hA, 1'b0};
        vecs[7]  = '{5,  12'h321, 1'b1, 1'b0, 4'h5, 1'b1, 1'b1, 1'b0, 12'h321, 4'h5, 1'b1};
        vecs[8]  = '{3,  12'h000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 12'h125, 4'hA, 1'b0};
        vecs[9]  = '{5,  12'h7FF, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 12'h321, 4'h5, 1'b0};
        vecs[10] = '{0,  12'h000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 12'h000, 4'h0, 1'b1};
        vecs[11] = '{31, 12'hFFE, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 12'hFFE, 4'h0, 1'b0};
        vecs[12] = '{31, 12'h000, 1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 12'hFFF, 4'hF, 1'b0};
        vecs[13] = '{31, 12'h000, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 12'h000, 4'hF, 1'b0};

        reset = 1'b1;
        clr_main();  b.rthreadid = '0; b.wthreadid = '0;
        clr_small(); s.rthreadid = '0; s.wthreadid = '0;
        do_reset();

        // ---------------- reset state ----------------
        b.rthreadid = 5'd0; #1;
        check("rst_next_thread", 32'(b.next_thread), 32'd0);
        check("rst_next_valid",  32'(b.next_valid),  32'd1);
        check("rst_cur_thread",  32'(b.cur_thread),  32'd31);
        check("rst_qpc0",        32'(b.qpc),         32'h000);
        check("rst_qflags0",     32'(b.qflags),      32'h0);
        check("rst_qrun0",       32'(b.qrun),        32'd1);
        b.rthreadid = 5'd17; #1;
        check("rst_qrun17",      32'(b.qrun),        32'd0);

        // ---------------- vector table through scoreboard ----------------
        foreach (vecs[i]) begin
            clr_main();
            b.wthreadid = TW'(vecs[i].tid);
            b.dpc       = vecs[i].dpc;
            b.wepc      = vecs[i].wepc;
            b.incpc     = vecs[i].incpc;
            b.dflags    = vecs[i].dflags;
            b.weflags   = vecs[i].weflags;
            b.setrun    = vecs[i].setrun;
            b.clrrun    = vecs[i].clrrun;
            sb.push_back('{$sformatf("vec%0d", i), vecs[i].tid,
                           32'(vecs[i].epc), 32'(vecs[i].eflags), 32'(vecs[i].erun)});
            tick();
            clr_main();
            sb_check();
        end

        // ---------------- per-thread PC write sweep ----------------
        for (int p = 0; p < T; p++) begin
            b.wthreadid = TW'(p);
            b.wepc = 1'b1;
            b.dpc = 12'hAAA; tick();
            b.dpc = 12'h555; tick();
            b.dpc = PW'(p);  tick();
        end
        clr_main();
        for (int p = 0; p < T; p++) begin
            b.rthreadid = TW'(p); #1;
            check($sformatf("sweep_pc%0d", p), 32'(b.qpc), 32'(p));
        end
        b.rthreadid = 5'd3; #1;
        check("sweep_flags3", 32'(b.qflags), 32'hA);
        b.rthreadid = 5'd31; #1;
        check("sweep_flags31", 32'(b.qflags), 32'hF);

        // ---------------- round-robin sequence ----------------
        do_reset();
        begin
            int seq [5] = '{0, 2, 7, 31, 0};
            b.setrun = 1'b1;
            b.wthreadid = 5'd2;  tick();
            b.wthreadid = 5'd7;  tick();
            b.wthreadid = 5'd31; tick();
            clr_main();
            b.sched_en = 1'b1;
            for (int k = 0; k < 5; k++) begin
                tick();
                check($sformatf("rr_cur%0d", k), 32'(b.cur_thread), 32'(seq[k]));
            end
            clr_main();
        end

        // ---------------- no runnable thread, then wake one ----------------
        b.clrrun = 1'b1;
        for (int p = 0; p < T; p++) begin
            b.wthreadid = TW'(p);
            tick();
        end
        clr_main(); #1;
        check("idle_valid", 32'(b.next_valid),  32'd0);
        check("idle_next",  32'(b.next_thread), 32'd0);
        b.sched_en = 1'b1;
        tick();
        check("idle_cur_hold", 32'(b.cur_thread), 32'd0);
        b.wthreadid = 5'd9; b.setrun = 1'b1; #1;
        check("wake_same_cycle_valid", 32'(b.next_valid), 32'd0);
        tick();
        b.setrun = 1'b0;
        #1;
        check("wake_cur_hold", 32'(b.cur_thread),  32'd0);
        check("wake_next",     32'(b.next_thread), 32'd9);
        check("wake_valid",    32'(b.next_valid),  32'd1);
        tick();
        clr_main(); #1;
        check("only_cur", 32'(b.cur_thread),  32'd9);
        check("only_next",  32'(b.next_thread), 32'd9);
        check("only_valid", 32'(b.next_valid),  32'd1);

        // ---------------- reset overrides same-cycle write ----------------
        b.wthreadid = 5'd10; b.rthreadid = 5'd10;
        b.wepc = 1'b1; b.dpc = 12'h456;
        b.weflags = 1'b1; b.dflags = 4'h5; b.setrun = 1'b1;
        tick();
        clr_main(); #1;
        check("pre_rst_pc",    32'(b.qpc),    32'h456);
        check("pre_rst_flags", 32'(b.qflags), 32'h5);
        check("pre_rst_run",   32'(b.qrun),   32'd1);
        b.wepc = 1'b1; b.dpc = 12'h777; b.sched_en = 1'b1; b.setrun = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clr_main(); #1;
        check("ovr_pc",    32'(b.qpc),        32'h000);
        check("ovr_flags", 32'(b.qflags),     32'h0);
        check("ovr_run",   32'(b.qrun),       32'd0);
        check("ovr_cur",   32'(b.cur_thread), 32'd31);

        // ---------------- 4-thread / 16-bit instance ----------------
        do_reset();
        s.rthreadid = 2'd2; #1;
        check("s_rst_pc",  32'(s.qpc),        32'(S_RESET_PC));
        check("s_rst_cur", 32'(s.cur_thread), 32'd3);
        check("s_rst_next", 32'(s.next_thread), 32'd0);
        for (int p = 0; p < ST; p++) begin
            s.wthreadid = STW'(p);
            s.wepc = 1'b1;
            s.dpc = 16'hAAAA; tick();
            s.dpc = 16'h5555; tick();
            s.dpc = SPW'(p);  tick();
        end
        clr_small();
        for (int p = 0; p < ST; p++) begin
            s.rthreadid = STW'(p); #1;
            check($sformatf("s_sweep_pc%0d", p), 32'(s.qpc), 32'(p));
        end
        s.wthreadid = 2'd1; s.rthreadid = 2'd1;
        s.wepc = 1'b1; s.dpc = 16'hFFFF; tick();
        s.wepc = 1'b0; s.incpc = 1'b1; tick();
        clr_small(); #1;
        check("s_wrap_pc", 32'(s.qpc), 32'h0000);
        begin
            int sseq [5] = '{0, 2, 3, 0, 2};
            s.setrun = 1'b1;
            s.wthreadid = 2'd2; tick();
            s.wthreadid = 2'd3; tick();
            clr_small();
            s.sched_en = 1'b1;
            for (int k = 0; k < 5; k++) begin
                tick();
                check($sformatf("s_rr_cur%0d", k), 32'(s.cur_thread), 32'(sseq[k]));
            end
            clr_small();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
